tff_sequence_checker: RTL
=========================

# tff_sequence_checker

Synthesizable stimulus-and-check engine for a T flip-flop with active-low preset and clear. It drives T, preset and clear into the flip-flop block, samples Q and Q̄, and compares them against an internal reference model. Results go to LEDs as pass/fail counts and a first-failure index. It sits beside the flip-flop on the same clock, so the circuit can self-test on the board without a simulator bench.

## Interface
- DUT_LATENCY, 1: clock edges from the flip-flop capturing its inputs until Q/Q̄ are valid at this block's inputs; legal range 1..7.
- input_clock1_c_1  in  1  system clock; the flip-flop under test uses the same clock.
- input_push_button2_reset_2  in  1  reset, synchronous, active-high.
- input_push_button3_start_3  in  1  begin a run; level-sampled.
- input_input_switch4_q_4  in  1  Q from the flip-flop.
- input_input_switch5_qbar_5  in  1  Q̄ from the flip-flop.
- output_led1_t_6  out  1  T drive.
- output_led2_preset_n_7  out  1  preset drive, active-low.
- output_led3_clear_n_8  out  1  clear drive, active-low.
- output_led4_busy_9  out  1  run in progress.
- output_led5_done_10  out  1  run complete; held until the next start or reset.
- output_led6_all_pass_11  out  1  done and fail count = 0.
- output_hexdisplay1_pass_12  out  5  pass count.
- output_hexdisplay2_fail_13  out  5  fail count.
- output_hexdisplay3_first_fail_14  out  4  index of the first failing vector.
- output_led7_fail_seen_15  out  1  first_fail is valid.

## Operation
- Fixed 14-entry vector ROM. Each entry is {T, preset_n, clear_n} → expected Q:
  - 0: {0,1,0}→0
  - 1: {0,1,1}→0
  - 2: {1,1,1}→1
  - 3: {1,1,1}→0
  - 4: {0,1,1}→0
  - 5: {1,1,1}→1
  - 6: {0,1,1}→1
  - 7: {0,0,1}→1
  - 8: {1,1,1}→0
  - 9: {1,1,0}→0
  - 10: {0,1,1}→0
  - 11: {1,1,1}→1
  - 12: {1,1,1}→0
  - 13: {1,1,1}→1
- Expected Q comes from a reference-model register that applies these rules in order:
  - clear_n=0 → 0
  - else preset_n=0 → 1
  - else T=1 → toggle
  - else hold
- The model register is cleared by vector 0. The ROM never asserts preset_n=0 and clear_n=0 together.
- FSM states:
  - IDLE: start=1 → APPLY. Entering APPLY zeroes counters, fail_seen and index, and sets busy=1.
  - APPLY: 1 cycle. Outputs carry vector[index]; the model updates. → WAIT.
  - WAIT: DUT_LATENCY cycles. Outputs idle (T=0, preset_n=1, clear_n=1). → CHECK.
  - CHECK: 1 cycle. Sample Q and Q̄; the vector passes iff Q ≠ Q̄ and Q = model.
    - pass: pass++.
    - fail: fail++; if fail_seen=0, latch first_fail = index and set fail_seen=1.
    - then: index=13 → DONE; else index++ and → APPLY.
  - DONE: busy=0, done=1. start=1 → APPLY, with the same clearing as from IDLE.
- start while busy is ignored.
- Counters saturate at 31 (unreachable with 14 vectors, but required).

## Timing
- All outputs are registered; drives change on the edge that enters or leaves APPLY.
- The vector is visible for exactly one cycle, so the flip-flop sees exactly one capturing edge with T=1. Holding T longer is forbidden because it would multi-toggle.
- Vector period is DUT_LATENCY+2 cycles. A full run is 14·(DUT_LATENCY+2) cycles after the start is sampled; 42 cycles at the default.
- done, all_pass, the counters and first_fail are stable from the first DONE cycle.
- Reset values:
  - T=0, preset_n=1, clear_n=1
  - busy=0, done=0, all_pass=0
  - pass=0, fail=0, first_fail=0, fail_seen=0
  - model=0, index=0, state IDLE
- Reset has priority over start. Reset mid-run aborts within 1 cycle, with drives returned to idle. start must be re-asserted after reset is released.
- Q/Q̄ are sampled only in CHECK; values in other states are don't-care.

## Test plan
- Correct T flip-flop model (latency 1): reset, then start for 1 cycle → done at cycle 42, pass=14, fail=0, all_pass=1, fail_seen=0.
- Flip-flop with Q stuck at 0 → fail=6 (vectors 2,5,6,7,11,13), pass=8, first_fail=2, all_pass=0.
- Q̄ tied equal to Q (non-complementary) → fail=14, first_fail=0.
- Reset asserted in the APPLY of vector 5 → next cycle: busy=0, T=0, preset_n=1, clear_n=1, counters 0. A later start re-runs all 14 vectors to pass=14.
- start held high through the run and into DONE → no restart while busy. DONE lasts 1 cycle, then a new run begins with counters cleared.
- DUT_LATENCY=3 with a flip-flop delayed by 2 extra stages → pass=14, done at cycle 70. The same flip-flop with DUT_LATENCY=1 → fail>0.

Source files
------------

// File: rtl/tff_sequence_checker.sv
// Self-test engine for a T flip-flop: plays a 14-vector ROM and checks Q/Qbar against a reference model.
// Vector period DUT_LATENCY+2 cycles, all outputs registered; start is ignored while busy, with no backpressure.
module tff_sequence_checker #(
    parameter int unsigned DUT_LATENCY = 1  // legal range 1..7
) (
    input  logic       input_clock1_c_1,
    input  logic       input_push_button2_reset_2,
    input  logic       input_push_button3_start_3,
    input  logic       input_input_switch4_q_4,
    input  logic       input_input_switch5_qbar_5,
    output logic       output_led1_t_6,
    output logic       output_led2_preset_n_7,
    output logic       output_led3_clear_n_8,
    output logic       output_led4_busy_9,
    output logic       output_led5_done_10,
    output logic       output_led6_all_pass_11,
    output logic [4:0] output_hexdisplay1_pass_12,
    output logic [4:0] output_hexdisplay2_fail_13,
    output logic [3:0] output_hexdisplay3_first_fail_14,
    output logic       output_led7_fail_seen_15
);

    localparam logic [3:0] LAST_IDX  = 4'd13;
    localparam logic [2:0] WAIT_INIT = 3'(DUT_LATENCY - 1);
    localparam logic [4:0] CNT_MAX   = 5'd31;
    localparam logic [2:0] IDLE_DRV  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Vector encoding is {t, preset_n, clear_n}.
    function automatic logic [2:0] vec_rom(input logic [3:0] idx);
        logic [2:0] v;
        case (idx)
            4'd0:    v = 3'b010;
            4'd1:    v = 3'b011;
            4'd2:    v = 3'b111;
            4'd3:    v = 3'b111;
            4'd4:    v = 3'b011;
            4'd5:    v = 3'b111;
            4'd6:    v = 3'b011;
            4'd7:    v = 3'b001;
            4'd8:    v = 3'b111;
            4'd9:    v = 3'b110;
            4'd10:   v = 3'b011;
            4'd11:   v = 3'b111;
            4'd12:   v = 3'b111;
            4'd13:   v = 3'b111;
            default: v = IDLE_DRV;
        endcase
        return v;
    endfunction

    function automatic logic model_step(input logic cur, input logic [2:0] v);
        logic nxt;
        if (!v[0]) begin
            nxt = 1'b0;
        end else if (!v[1]) begin
            nxt = 1'b1;
        end else if (v[2]) begin
            nxt = ~cur;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == CNT_MAX) ? v : v + 5'd1;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] wait_q, wait_d;
    logic       t_q, t_d;
    logic       preset_n_q, preset_n_d;
    logic       clear_n_q, clear_n_d;
    logic       model_q, model_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       all_pass_q, all_pass_d;
    logic [4:0] pass_q, pass_d;
    logic [4:0] fail_q, fail_d;
    logic [3:0] first_fail_q, first_fail_d;
    logic       fail_seen_q, fail_seen_d;

    logic       launch;
    logic       load_vec;
    logic [3:0] load_idx;
    logic [2:0] vec;
    logic       vec_pass;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        // Drives fall back to idle every cycle; a vector is loaded only on entry to APPLY.
        t_d          = 1'b0;
        preset_n_d   = 1'b1;
        clear_n_d    = 1'b1;
        model_d      = model_q;
        busy_d       = busy_q;
        done_d       = done_q;
        all_pass_d   = all_pass_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        launch       = 1'b0;
        load_vec     = 1'b0;
        load_idx     = idx_q;
        vec_pass     = (input_input_switch4_q_4 != input_input_switch5_qbar_5) &&
                       (input_input_switch4_q_4 == model_q);

        case (state_q)
            ST_IDLE: begin
                launch = input_push_button3_start_3;
            end
            ST_APPLY: begin
                state_d = ST_WAIT;
                wait_d  = WAIT_INIT;
            end
            ST_WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_CHECK: begin
                if (vec_pass) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                    if (!fail_seen_q) begin
                        first_fail_d = idx_q;
                        fail_seen_d  = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    all_pass_d = (fail_d == 5'd0);
                end else begin
                    state_d  = ST_APPLY;
                    idx_d    = idx_q + 4'd1;
                    load_vec = 1'b1;
                    load_idx = idx_q + 4'd1;
                end
            end
            ST_DONE: begin
                launch = input_push_button3_start_3;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_d      = ST_APPLY;
            idx_d        = 4'd0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            all_pass_d   = 1'b0;
            pass_d       = 5'd0;
            fail_d       = 5'd0;
            first_fail_d = 4'd0;
            fail_seen_d  = 1'b0;
            load_vec     = 1'b1;
            load_idx     = 4'd0;
        end

        // The model advances together with the vector so it holds the expected Q by CHECK.
        vec = vec_rom(load_idx);
        if (load_vec) begin
            t_d        = vec[2];
            preset_n_d = vec[1];
            clear_n_d  = vec[0];
            model_d    = model_step(model_q, vec);
        end
    end

    always_ff @(posedge input_clock1_c_1) begin
        if (input_push_button2_reset_2) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            wait_q       <= 3'd0;
            t_q          <= 1'b0;
            preset_n_q   <= 1'b1;
            clear_n_q    <= 1'b1;
            model_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            all_pass_q   <= 1'b0;
            pass_q       <= 5'd0;
            fail_q       <= 5'd0;
            first_fail_q <= 4'd0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            t_q          <= t_d;
            preset_n_q   <= preset_n_d;
            clear_n_q    <= clear_n_d;
            model_q      <= model_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            all_pass_q   <= all_pass_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign output_led1_t_6                  = t_q;
    assign output_led2_preset_n_7           = preset_n_q;
    assign output_led3_clear_n_8            = clear_n_q;
    assign output_led4_busy_9               = busy_q;
    assign output_led5_done_10              = done_q;
    assign output_led6_all_pass_11          = all_pass_q;
    assign output_hexdisplay1_pass_12       = pass_q;
    assign output_hexdisplay2_fail_13       = fail_q;
    assign output_hexdisplay3_first_fail_14 = first_fail_q;
    assign output_led7_fail_seen_15         = fail_seen_q;

endmodule
